// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Central sequencing controller for a 5-stage pipeline. Combines the
//   instruction/data cache completions, load-use hazards, taken-branch/jump
//   redirects and HALT into per-latch enable and flush strobes plus the PC
//   load enable. Early cache completions are remembered (i_held / d_held)
//   so the caches are not asked again while the other side is still busy.
//   Saturating performance counters track cycles, stalls and flushes.
//
// Ports
//   CLK, nRST                     clock, asynchronous active-low reset
//   ihit, dhit                    icache / dcache completion this cycle
//   exmem_dREN, exmem_dWEN        MEM-stage instruction accesses dmem
//   exmem_pcsrc                   MEM stage resolved a taken redirect
//   idex_MemtoReg, idex_wsel      EX-stage load and its destination
//   ifid_rs, ifid_rt              ID-stage source registers
//   memwb_halt                    WB-stage instruction is HALT
//   pc_en                         PC load enable
//   ifid/idex/exmem/memwb_en      latch enables
//   ifid/idex/exmem_flush         latch loads a bubble on this edge
//   imem_mask, dmem_mask          suppress re-request of a captured access
//   halt                          sticky processor halt
//   cycle_cnt, stall_cnt, flush_cnt  saturating perf counters
//   state_dbg                     current FSM state (1 = HALTED)
//
// Handshake: ihit/dhit are per-cycle completion indications from the
// caches. The pipeline advances (adv) only in a cycle where both the fetch
// and any outstanding data access are complete, either now or earlier
// (held). A held completion is consumed by the advance that uses it.
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             exmem_pcsrc,
  input  logic             idex_MemtoReg,
  input  logic [REG_W-1:0] idex_wsel,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             memwb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             imem_mask,
  output logic             dmem_mask,
  output logic             halt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             state_dbg
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;
  logic   i_held, d_held;

  logic run, mem_req, i_ok, d_ok, adv;
  logic load_use, redirect, lu_stall, stall_evt;

  // Next-state and strobe generation.
  always_comb begin
    state_d     = state_q;
    run         = 1'b0;
    mem_req     = 1'b0;
    i_ok        = 1'b0;
    d_ok        = 1'b0;
    adv         = 1'b0;
    load_use    = 1'b0;
    redirect    = 1'b0;
    lu_stall    = 1'b0;
    stall_evt   = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    imem_mask   = 1'b0;
    dmem_mask   = 1'b0;

    // nRST gates everything so strobes are quiet while reset is held,
    // even though the state register already sits in RUN.
    run      = (state_q == RUN) && nRST;
    mem_req  = exmem_dREN | exmem_dWEN;
    i_ok     = ihit | i_held;
    d_ok     = !mem_req | dhit | d_held;
    adv      = run & i_ok & d_ok;
    load_use = idex_MemtoReg && (idex_wsel != '0) &&
               ((idex_wsel == ifid_rs) || (idex_wsel == ifid_rt));
    redirect = adv & exmem_pcsrc;
    // Redirect squashes the dependent instruction anyway, so it wins.
    lu_stall = adv & load_use & !exmem_pcsrc;
    stall_evt = run & (!adv | lu_stall);

    pc_en       = adv & !lu_stall;
    ifid_en     = adv & !lu_stall;
    idex_en     = adv;
    exmem_en    = adv;
    memwb_en    = adv;
    ifid_flush  = redirect;
    idex_flush  = redirect | lu_stall;
    exmem_flush = redirect;

    imem_mask = i_held & run;
    dmem_mask = d_held & run;

    if (adv && memwb_halt) state_d = HALTED;
  end

  assign halt      = (state_q == HALTED);
  assign state_dbg = state_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Held completion flags: remember a completion that arrived in a cycle
  // that could not advance; the next advance consumes it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      i_held <= 1'b0;
      d_held <= 1'b0;
    end else begin
      if (adv)              i_held <= 1'b0;
      else if (run && ihit) i_held <= 1'b1;
      if (adv)                         d_held <= 1'b0;
      else if (run && mem_req && dhit) d_held <= 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (run && (cycle_cnt != '1))       cycle_cnt <= cycle_cnt + CNT_ONE;
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if (redirect && (flush_cnt != '1))  flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Drives a full-width instance and a 4-bit-counter instance with the same
//   stimulus. A reference model describes each cycle as one pipeline action
//   (frozen, normal advance, load-use bubble, redirect) and pushes the
//   expected outputs into exp_q; a monitor on the falling edge pops and
//   compares against both instances.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int REG_W = 5;
  localparam int OW    = 11 + 11 + 3*32 + 3*4;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  logic ihit, dhit, exmem_dREN, exmem_dWEN, exmem_pcsrc, idex_MemtoReg, memwb_halt;
  logic [REG_W-1:0] idex_wsel, ifid_rs, ifid_rt;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, imem_mask, dmem_mask, halt, state_dbg;
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

  logic s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic s_ifid_flush, s_idex_flush, s_exmem_flush, s_imem_mask, s_dmem_mask, s_halt, s_state_dbg;
  logic [3:0] s_cycle_cnt, s_stall_cnt, s_flush_cnt;

  pipeline_ctrl #(.REG_W(REG_W), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN), .exmem_pcsrc(exmem_pcsrc),
    .idex_MemtoReg(idex_MemtoReg), .idex_wsel(idex_wsel),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .memwb_halt(memwb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .imem_mask(imem_mask), .dmem_mask(dmem_mask),
    .halt(halt), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .state_dbg(state_dbg)
  );

  pipeline_ctrl #(.REG_W(REG_W), .CNT_W(4)) dut_s (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN), .exmem_pcsrc(exmem_pcsrc),
    .idex_MemtoReg(idex_MemtoReg), .idex_wsel(idex_wsel),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .memwb_halt(memwb_halt),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
    .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .exmem_flush(s_exmem_flush), .imem_mask(s_imem_mask), .dmem_mask(s_dmem_mask),
    .halt(s_halt), .cycle_cnt(s_cycle_cnt), .stall_cnt(s_stall_cnt),
    .flush_cnt(s_flush_cnt), .state_dbg(s_state_dbg)
  );

  // ---------------- reference model ----------------
  typedef enum {ACT_FROZEN, ACT_NORMAL, ACT_BUBBLE, ACT_REDIRECT} act_e;

  bit          m_halted, m_fetch_cap, m_data_done;
  int unsigned m_cyc, m_stl, m_fl;

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, exmem_flush}
  function automatic logic [7:0] strobes(act_e a);
    case (a)
      ACT_NORMAL:   return 8'b11111_000;
      ACT_BUBBLE:   return 8'b00111_010;
      ACT_REDIRECT: return 8'b11111_111;
      default:      return 8'b00000_000;
    endcase
  endfunction

  function automatic logic [3:0] sat4(int unsigned v);
    logic [3:0] r;
    r = (v > 15) ? 4'hF : 4'(v);
    return r;
  endfunction

  logic [OW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;

  // ---------------- driver ----------------
  task automatic step(input bit rn, input bit ih, input bit dh, input bit rd,
                      input bit wr, input bit pcs, input bit m2r,
                      input logic [REG_W-1:0] ws, input logic [REG_W-1:0] rs,
                      input logic [REG_W-1:0] rt, input bit hl_in);
    logic [7:0]  st;
    logic [2:0]  flags;
    logic [OW-1:0] e;
    act_e a;
    bit mem, go, haz;
    @(posedge CLK);
    #1;
    nRST = rn; ihit = ih; dhit = dh; exmem_dREN = rd; exmem_dWEN = wr;
    exmem_pcsrc = pcs; idex_MemtoReg = m2r; idex_wsel = ws;
    ifid_rs = rs; ifid_rt = rt; memwb_halt = hl_in;
    if (!rn) begin
      m_halted = 0; m_fetch_cap = 0; m_data_done = 0;
      m_cyc = 0; m_stl = 0; m_fl = 0;
      e = '0;
    end else begin
      a = ACT_FROZEN;
      if (m_halted) begin
        flags = 3'b001;
      end else begin
        flags = {m_fetch_cap, m_data_done, 1'b0};
        mem = rd || wr;
        go  = (ih || m_fetch_cap) && (!mem || dh || m_data_done);
        haz = m2r && (ws != 0) && (ws == rs || ws == rt);
        if (!go) begin
          if (ih) m_fetch_cap = 1;
          if (mem && dh) m_data_done = 1;
        end else begin
          m_fetch_cap = 0; m_data_done = 0;
          if (pcs)      a = ACT_REDIRECT;
          else if (haz) a = ACT_BUBBLE;
          else          a = ACT_NORMAL;
        end
      end
      st = strobes(a);
      // Counters visible this cycle are the totals of earlier cycles.
      e = {st, flags, st, flags, m_cyc, m_stl, m_fl,
           sat4(m_cyc), sat4(m_stl), sat4(m_fl)};
      if (!m_halted) begin
        m_cyc++;
        if (a == ACT_FROZEN || a == ACT_BUBBLE) m_stl++;
        if (a == ACT_REDIRECT) m_fl++;
        if (a != ACT_FROZEN && hl_in) m_halted = 1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit ih);
    for (int i = 0; i < n; i++) step(1, ih, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    logic [OW-1:0] got, e;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, imem_mask, dmem_mask, halt,
             s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en,
             s_ifid_flush, s_idex_flush, s_exmem_flush, s_imem_mask, s_dmem_mask, s_halt,
             cycle_cnt, stall_cnt, flush_cnt, s_cycle_cnt, s_stall_cnt, s_flush_cnt};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got %h expected %h", cyc_no, got, e);
      end
      cyc_no++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int halted_for;
    nRST = 0; ihit = 0; dhit = 0; exmem_dREN = 0; exmem_dWEN = 0; exmem_pcsrc = 0;
    idex_MemtoReg = 0; idex_wsel = 0; ifid_rs = 0; ifid_rt = 0; memwb_halt = 0;

    do_reset();
    // Straight-line fetch: advance every cycle, counters 10/0 afterwards.
    idle(11, 1);

    // Load waiting on dcache; fetch captured early and held.
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 1);

    // Store completes before the fetch: d_held path.
    step(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // ihit and dhit together with a memory access.
    step(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);

    // Load-use on rt, then r0 destination (no stall), then on rs.
    step(1, 1, 0, 0, 0, 0, 1, 8, 3, 8, 0);
    step(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1, 5, 5, 2, 0);
    // Redirect together with load-use: redirect wins.
    step(1, 1, 0, 0, 0, 1, 1, 8, 8, 8, 0);
    idle(1, 1);

    // Redirect and halt in the same advancing cycle; halt ignored when frozen.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    idle(3, 1);
    do_reset();
    idle(2, 1);

    // Reset in the middle of a stall with a held fetch.
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Long stall: the 4-bit counters must stick at 15.
    idle(22, 0);
    idle(3, 1);

    // Randomized traffic with periodic resets.
    halted_for = 0;
    for (int i = 0; i < 3000; i++) begin
      if (halted_for > 3 || $urandom_range(0, 199) == 0) begin
        do_reset();
        halted_for = 0;
      end else begin
        step(1, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
             $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1,
             $urandom_range(0, 99) < 15, $urandom_range(0, 9) < 3,
             REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
             REG_W'($urandom_range(0, 3)), $urandom_range(0, 99) < 3);
        if (m_halted) halted_for++;
      end
    end

    @(negedge CLK);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencing controller for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Merges instruction/data cache handshakes, load-use hazards, taken-branch/jump redirects and halt into per-stage enable and flush strobes.
- Latches early cache completions so no cache request is reissued while the other cache is still busy.
- Keeps saturating performance counters for cycles, stalls and flushes.

Parameters:
REG_W, 5, register-index width
CNT_W, 32, performance counter width

Ports:
CLK  in  1  clock
nRST  in  1  async active-low reset
ihit  in  1  icache returns instruction this cycle
dhit  in  1  dcache completes access this cycle
exmem_dREN  in  1  MEM-stage instruction reads dmem
exmem_dWEN  in  1  MEM-stage instruction writes dmem
exmem_pcsrc  in  1  MEM stage resolved taken branch/jump/jr
idex_MemtoReg  in  1  EX-stage instruction is a load
idex_wsel  in  REG_W  EX-stage destination register
ifid_rs  in  REG_W  ID-stage source rs
ifid_rt  in  REG_W  ID-stage source rt
memwb_halt  in  1  WB-stage instruction is HALT
pc_en  out  1  PC load enable
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
ifid_flush, idex_flush, exmem_flush  out  1 each  latch loads zero (bubble) on this edge
imem_mask  out  1  suppress iREN (fetch already captured)
dmem_mask  out  1  suppress dREN/dWEN (access already done)
halt  out  1  sticky processor halt
cycle_cnt, stall_cnt, flush_cnt  out  CNT_W each  perf counters

Behaviour:
- Clock and reset: one clock (CLK); reset (nRST) is asynchronous and active-low.
- State: FSM {RUN, HALTED}; flags i_held, d_held. On reset: RUN, flags 0, counters 0, halt 0.
- While nRST low, all enables, flushes, pc_en and masks are forced 0.
- Derived signals:
  - mem_req = exmem_dREN | exmem_dWEN.
  - i_ok = ihit | i_held.
  - d_ok = !mem_req | dhit | d_held.
  - adv = (state==RUN) & i_ok & d_ok.
- !adv: all enables, flushes and pc_en are 0. Pipeline frozen.
- adv, no hazard: all four enables 1, pc_en 1, flushes 0.
- Load-use = idex_MemtoReg & idex_wsel!=0 & (idex_wsel==ifid_rs | idex_wsel==ifid_rt). With adv and no redirect:
  - pc_en=0, ifid_en=0 (hold).
  - idex_en=1 with idex_flush=1 (bubble).
  - exmem_en=1, memwb_en=1.
- Redirect (exmem_pcsrc & adv): pc_en=1 (PC takes target), all enables 1, ifid_flush=idex_flush=exmem_flush=1.
  - Redirect has priority over load-use.
- Flush outputs are asserted only when adv=1. A flush with its enable 0 never occurs.
- i_held:
  - Set when ihit & !adv.
  - Cleared on adv.
  - Stays set through further ihit.
- d_held: set when mem_req & dhit & !adv; cleared on adv.
- Masks: imem_mask=i_held, dmem_mask=d_held (combinational).
- Halt:
  - memwb_halt & adv moves the FSM to HALTED next edge.
  - In HALTED: halt=1, adv=0, masks 0. Exit only via reset.
  - memwb_halt without adv is ignored.
- Counters (saturate at all-ones, no wrap):
  - cycle_cnt: +1 every RUN cycle.
  - stall_cnt: +1 every RUN cycle with !adv, or with adv & load-use & !exmem_pcsrc.
  - flush_cnt: +1 every cycle a redirect flush is issued.
- Simultaneous events:
  - ihit & dhit in the same cycle with mem_req: adv, no held flags set.
  - Redirect and halt in the same adv cycle: halt wins the state transition; flush strobes still issue that cycle.
- Reset mid-stall: held flags and FSM clear immediately (async); counters clear.

Test Plan:
- Reset, then ihit=1, mem_req=0 for 10 cycles -> all enables 1 and pc_en 1 each cycle; cycle_cnt=10, stall_cnt=0.
- Load stall: dREN=1, ihit=1 at cycle 0, dhit=1 at cycle 3 -> i_held=1 and imem_mask=1 for cycles 1-3, enables 0 on cycles 0-2, adv at cycle 3; i_held=0 at cycle 4; stall_cnt=3.
- Load-use: idex_MemtoReg=1, idex_wsel=8, ifid_rt=8, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1. Same stimulus with idex_wsel=0 -> no stall.
- Redirect plus load-use in the same adv cycle -> three flushes 1, pc_en=1, ifid_en=1; flush_cnt +1, stall_cnt unchanged.
- memwb_halt=1 with adv -> halt=1 next cycle, all enables 0 thereafter despite ihit. nRST pulse -> halt=0, RUN.
- Preload stall_cnt near max via long dhit-less stall (CNT_W=4 build) -> saturates at 15, no wrap.
